// File: rtl/noc_bridge_pkg.sv
// rtl/noc_bridge_pkg.sv - shared types and default configuration of the NoC bridge link scheduler
// Purpose: scheduler FSM states, the registered link beat and the credit type.
// Ports: none. The beat/credit widths follow the default bridge configuration
// below; the scheduler and credit counters take their defaults from it.
package noc_bridge_pkg;

  localparam int unsigned NOC_NUM_VC   = 2;
  localparam int unsigned NOC_NUM_CRED = 8;
  localparam int unsigned NOC_CRED_W   = $clog2(NOC_NUM_CRED + 1);
  localparam int unsigned NOC_VC_IDX_W = (NOC_NUM_VC > 1) ? $clog2(NOC_NUM_VC) : 1;

  typedef enum logic {
    ARB   = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

  typedef logic [NOC_CRED_W-1:0] bridge_credit_t;

  typedef struct packed {
    logic                    data_valid;
    logic [NOC_VC_IDX_W-1:0] data_vc;
    logic [NOC_VC_IDX_W-1:0] cred_vc;
    bridge_credit_t          cred;
  } sched_beat_t;

endpackage

// File: rtl/noc_bridge_vc_credit_ctr.sv
// rtl/noc_bridge_vc_credit_ctr.sv - per-VC remote and owed credit counters
// Purpose: tracks the far side's free receive slots (remote) and the local
// slots freed but not yet reported (owed) for one virtual channel.
// Ports: clk_i/rst_i clock and sync active-high reset; consumed_i local pop;
// recv_i credits returned by the far side; data_sent_i one flit committed;
// cred_sent_i credits committed on the link; remote_o/owed_o counters;
// err_o sticky remote overflow.
module noc_bridge_vc_credit_ctr
  import noc_bridge_pkg::*;
#(
  parameter int unsigned NumCred = NOC_NUM_CRED,
  parameter int unsigned CredW   = $clog2(NumCred + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             consumed_i,
  input  logic [CredW-1:0] recv_i,
  input  logic             data_sent_i,
  input  logic [CredW-1:0] cred_sent_i,
  output logic [CredW-1:0] remote_o,
  output logic [CredW-1:0] owed_o,
  output logic             err_o
);

  localparam logic [CredW:0] CredMax = (CredW + 1)'(NumCred);

  logic [CredW-1:0] remote_q, remote_d;
  logic [CredW-1:0] owed_q, owed_d;
  logic             err_q, err_d;
  logic [CredW:0]   remote_sum, owed_sum;

  // One extra bit so returned credits beyond the buffer depth are visible
  // before clamping; sent amounts never exceed the current count.
  always_comb begin
    remote_sum = {1'b0, remote_q} + {1'b0, recv_i} - (CredW + 1)'(data_sent_i);
    owed_sum   = {1'b0, owed_q} + (CredW + 1)'(consumed_i) - {1'b0, cred_sent_i};
    err_d      = err_q;
    if (remote_sum > CredMax) begin
      remote_d = CredMax[CredW-1:0];
      err_d    = 1'b1;
    end else begin
      remote_d = remote_sum[CredW-1:0];
    end
    owed_d = (owed_sum > CredMax) ? CredMax[CredW-1:0] : owed_sum[CredW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      remote_q <= CredW'(NumCred);
      owed_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      remote_q <= remote_d;
      owed_q   <= owed_d;
      err_q    <= err_d;
    end
  end

  assign remote_o = remote_q;
  assign owed_o   = owed_q;
  assign err_o    = err_q;

endmodule

// File: rtl/noc_bridge_vc_link_scheduler.sv
// rtl/noc_bridge_vc_link_scheduler.sv - schedules data flits and credit returns onto the shared link
// Purpose: per cycle picks a round-robin data VC with remote credit and
// piggybacks the largest owed credit count, or forces a credit-only beat.
// Ports: vc_valid_i/vc_ready_o per-VC send handshake; vc_consumed_i local
// pops; cred_valid_i/cred_vc_i/cred_amount_i incoming credits; link_valid_o/
// link_ready_i link handshake; link_data_valid_o/link_data_vc_o/
// link_cred_vc_o/link_cred_o beat fields; remote_cred_o packed remote
// credits; cred_err_o sticky overflow; stat_* counters.
// Optional: NOC_BRIDGE_SCHED_STATS_EN enables the three statistics counters.
module noc_bridge_vc_link_scheduler
  import noc_bridge_pkg::*;
#(
  parameter int unsigned NumVc           = NOC_NUM_VC,
  parameter int unsigned NumCred         = NOC_NUM_CRED,
  parameter int unsigned ForceSendThresh = NumCred - 4,
  localparam int unsigned CredW          = $clog2(NumCred + 1),
  localparam int unsigned VcIdxW         = (NumVc > 1) ? $clog2(NumVc) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumVc-1:0]       vc_valid_i,
  output logic [NumVc-1:0]       vc_ready_o,
  input  logic [NumVc-1:0]       vc_consumed_i,
  input  logic                   cred_valid_i,
  input  logic [VcIdxW-1:0]      cred_vc_i,
  input  logic [CredW-1:0]       cred_amount_i,
  output logic                   link_valid_o,
  input  logic                   link_ready_i,
  output logic                   link_data_valid_o,
  output logic [VcIdxW-1:0]      link_data_vc_o,
  output logic [VcIdxW-1:0]      link_cred_vc_o,
  output logic [CredW-1:0]       link_cred_o,
  output logic [NumVc*CredW-1:0] remote_cred_o,
  output logic                   cred_err_o,
  output logic [31:0]            stat_data_beats_o,
  output logic [31:0]            stat_cred_beats_o,
  output logic [31:0]            stat_stall_cycles_o
);

  sched_state_e      state_q, state_d;
  sched_beat_t       beat_q, beat_d, cand;
  logic              link_valid_q, link_valid_d;
  logic [VcIdxW-1:0] rr_q, rr_d, rr_eff, rr_idx, data_sel, cred_sel;
  logic              handshake, data_found, cand_valid;
  bridge_credit_t    cred_max;

  bridge_credit_t    remote_cred [NumVc];
  bridge_credit_t    owed_cred   [NumVc];
  bridge_credit_t    remote_eff  [NumVc];
  bridge_credit_t    owed_eff    [NumVc];
  bridge_credit_t    cred_sent   [NumVc];
  bridge_credit_t    recv_cred   [NumVc];
  logic [NumVc-1:0]  data_sent, data_elig, vc_err;

  assign handshake = link_valid_q & link_ready_i;

  // Effective counts exclude whatever the beat in flight commits this cycle,
  // so a back-to-back load never reuses a credit that is just leaving.
  always_comb begin : commit_decode
    data_sent = '0;
    data_elig = '0;
    for (int v = 0; v < NumVc; v++) begin
      data_sent[v]  = handshake & beat_q.data_valid & (beat_q.data_vc == VcIdxW'(v));
      cred_sent[v]  = (handshake && beat_q.cred_vc == VcIdxW'(v)) ? beat_q.cred : '0;
      recv_cred[v]  = (cred_valid_i && cred_vc_i == VcIdxW'(v)) ? cred_amount_i : '0;
      remote_eff[v] = remote_cred[v] - CredW'(data_sent[v]);
      owed_eff[v]   = owed_cred[v] - cred_sent[v];
      data_elig[v]  = vc_valid_i[v] & (remote_eff[v] != '0);
    end
    rr_eff = (handshake && beat_q.data_valid) ?
             VcIdxW'((int'(beat_q.data_vc) + 1) % NumVc) : rr_q;
  end

  always_comb begin : select
    data_found = 1'b0;
    data_sel   = '0;
    rr_idx     = '0;
    cred_sel   = '0;
    cred_max   = '0;
    for (int i = 0; i < NumVc; i++) begin
      rr_idx = VcIdxW'((int'(rr_eff) + i) % NumVc);
      if (!data_found && data_elig[rr_idx]) begin
        data_found = 1'b1;
        data_sel   = rr_idx;
      end
    end
    // Strict compare keeps the lowest index on ties.
    for (int v = 0; v < NumVc; v++) begin
      if (owed_eff[v] > cred_max) begin
        cred_max = owed_eff[v];
        cred_sel = VcIdxW'(v);
      end
    end
    cand_valid      = data_found | (cred_max >= CredW'(ForceSendThresh));
    cand.data_valid = data_found;
    cand.data_vc    = data_sel;
    cand.cred_vc    = cred_sel;
    cand.cred       = cred_max;
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    beat_d       = beat_q;
    link_valid_d = link_valid_q;
    rr_d         = rr_eff;
    case (state_q)
      ARB: begin
        if (cand_valid) begin
          beat_d       = cand;
          link_valid_d = 1'b1;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          if (cand_valid) begin
            beat_d = cand;
          end else begin
            link_valid_d = 1'b0;
            state_d      = ARB;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB;
      beat_q       <= '0;
      link_valid_q <= 1'b0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      link_valid_q <= link_valid_d;
      rr_q         <= rr_d;
    end
  end

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    noc_bridge_vc_credit_ctr #(
      .NumCred (NumCred),
      .CredW   (CredW)
    ) u_credit_ctr (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .consumed_i  (vc_consumed_i[v]),
      .recv_i      (recv_cred[v]),
      .data_sent_i (data_sent[v]),
      .cred_sent_i (cred_sent[v]),
      .remote_o    (remote_cred[v]),
      .owed_o      (owed_cred[v]),
      .err_o       (vc_err[v])
    );
    assign remote_cred_o[v*CredW +: CredW] = remote_cred[v];
  end

  assign vc_ready_o        = data_sent;
  assign link_valid_o      = link_valid_q;
  assign link_data_valid_o = beat_q.data_valid;
  assign link_data_vc_o    = beat_q.data_vc;
  assign link_cred_vc_o    = beat_q.cred_vc;
  assign link_cred_o       = beat_q.cred;
  assign cred_err_o        = |vc_err;

`ifdef NOC_BRIDGE_SCHED_STATS_EN
  logic [31:0] stat_data_q, stat_data_d;
  logic [31:0] stat_cred_q, stat_cred_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_data_d  = stat_data_q + 32'(handshake & beat_q.data_valid);
    stat_cred_d  = stat_cred_q + 32'(handshake & ~beat_q.data_valid);
    stat_stall_d = stat_stall_q + 32'(link_valid_q & ~link_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_data_q  <= '0;
      stat_cred_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_data_q  <= stat_data_d;
      stat_cred_q  <= stat_cred_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_data_beats_o   = stat_data_q;
  assign stat_cred_beats_o   = stat_cred_q;
  assign stat_stall_cycles_o = stat_stall_q;
`else
  assign stat_data_beats_o   = '0;
  assign stat_cred_beats_o   = '0;
  assign stat_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_noc_bridge_vc_link_scheduler.sv
// tb/tb_noc_bridge_vc_link_scheduler.sv - self-checking bench for the VC link scheduler
module tb_noc_bridge_vc_link_scheduler;

  localparam int NV  = 2;
  localparam int NC  = 8;
  localparam int THR = 4;
  localparam int CW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  vc_valid = '0;
  logic [1:0]  vc_consumed = '0;
  logic        cred_valid = 1'b0;
  logic        cred_vc = 1'b0;
  logic [3:0]  cred_amount = '0;
  logic        link_ready = 1'b0;

  logic [1:0]  vc_ready_o;
  logic        link_valid_o, link_data_valid_o, link_data_vc_o, link_cred_vc_o, cred_err_o;
  logic [3:0]  link_cred_o;
  logic [7:0]  remote_cred_o;
  logic [31:0] stat_data_beats_o, stat_cred_beats_o, stat_stall_cycles_o;

  always #5 clk = ~clk;

  noc_bridge_vc_link_scheduler dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .vc_valid_i          (vc_valid),
    .vc_ready_o          (vc_ready_o),
    .vc_consumed_i       (vc_consumed),
    .cred_valid_i        (cred_valid),
    .cred_vc_i           (cred_vc),
    .cred_amount_i       (cred_amount),
    .link_valid_o        (link_valid_o),
    .link_ready_i        (link_ready),
    .link_data_valid_o   (link_data_valid_o),
    .link_data_vc_o      (link_data_vc_o),
    .link_cred_vc_o      (link_cred_vc_o),
    .link_cred_o         (link_cred_o),
    .remote_cred_o       (remote_cred_o),
    .cred_err_o          (cred_err_o),
    .stat_data_beats_o   (stat_data_beats_o),
    .stat_cred_beats_o   (stat_cred_beats_o),
    .stat_stall_cycles_o (stat_stall_cycles_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link state as counts and the beat currently offered.
  int          m_remote [NV];
  int          m_owed   [NV];
  int          m_rr, m_dvc, m_cvc, m_cred;
  bit          m_err, m_valid, m_dv;
  int unsigned m_sd, m_sc, m_ss;
  bit          model_ready = 1'b0;

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      m_remote[k] = NC;
      m_owed[k]   = 0;
    end
    m_rr = 0; m_dvc = 0; m_cvc = 0; m_cred = 0;
    m_err = 0; m_valid = 0; m_dv = 0;
    m_sd = 0; m_sc = 0; m_ss = 0;
  endtask

  // Advances the model across the next rising edge using the current inputs.
  task automatic model_step();
    int r_eff [NV];
    int o_eff [NV];
    int rr, pick, best, bvc, v;
    bit hs, cand;
    if (rst) begin
      model_reset();
      return;
    end
    hs = m_valid && link_ready;
    for (int k = 0; k < NV; k++) begin
      r_eff[k] = m_remote[k] - ((hs && m_dv && m_dvc == k) ? 1 : 0);
      o_eff[k] = m_owed[k] - ((hs && m_cvc == k) ? m_cred : 0);
    end
    rr   = (hs && m_dv) ? (m_dvc + 1) % NV : m_rr;
    pick = -1;
    for (int i = 0; i < NV; i++) begin
      v = (rr + i) % NV;
      if (pick < 0 && vc_valid[v] && r_eff[v] > 0) pick = v;
    end
    best = 0; bvc = 0;
    for (int k = 0; k < NV; k++) begin
      if (o_eff[k] > best) begin best = o_eff[k]; bvc = k; end
    end
    cand = (pick >= 0) || (best >= THR);
    if (hs && m_dv) m_sd++;
    if (hs && !m_dv) m_sc++;
    if (m_valid && !link_ready) m_ss++;
    if (!m_valid || hs) begin
      if (cand) begin
        m_valid = 1; m_dv = (pick >= 0);
        if (pick >= 0) m_dvc = pick;
        m_cvc = bvc; m_cred = best;
      end else begin
        m_valid = 0;
      end
    end
    for (int k = 0; k < NV; k++) begin
      m_owed[k] = o_eff[k] + int'(vc_consumed[k]);
      if (m_owed[k] > NC) m_owed[k] = NC;
      m_remote[k] = r_eff[k] + ((cred_valid && int'(cred_vc) == k) ? int'(cred_amount) : 0);
      if (m_remote[k] > NC) begin m_remote[k] = NC; m_err = 1; end
    end
    m_rr = rr;
  endtask

  task automatic compare_outputs();
    logic [7:0] exp_rem;
    logic [1:0] exp_rdy;
    for (int k = 0; k < NV; k++) exp_rem[k*CW +: CW] = 4'(m_remote[k]);
    exp_rdy = (m_valid && link_ready && m_dv) ? 2'(1 << m_dvc) : 2'b00;
    check("m_link_valid", link_valid_o, m_valid);
    check("m_vc_ready", vc_ready_o, exp_rdy);
    check("m_remote_cred", remote_cred_o, exp_rem);
    check("m_cred_err", cred_err_o, m_err);
    if (m_valid) begin
      check("m_data_valid", link_data_valid_o, m_dv);
      if (m_dv) check("m_data_vc", link_data_vc_o, m_dvc);
      check("m_cred_vc", link_cred_vc_o, m_cvc);
      check("m_cred", link_cred_o, m_cred);
    end
`ifdef NOC_BRIDGE_SCHED_STATS_EN
    check("m_stat_data", stat_data_beats_o, m_sd);
    check("m_stat_cred", stat_cred_beats_o, m_sc);
    check("m_stat_stall", stat_stall_cycles_o, m_ss);
`else
    check("m_stat_data", stat_data_beats_o, 0);
    check("m_stat_cred", stat_cred_beats_o, 0);
    check("m_stat_stall", stat_stall_cycles_o, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (model_ready) compare_outputs();
    model_step();
    model_ready = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if (link_valid_o) ok = 1'b1;
    end
    check({name, "_seen"}, ok, 1);
  endtask

  int g [40];
  int n, first;
  bit ok;

  initial begin
    // Reset state and round-robin drain of both VCs.
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_link_valid", link_valid_o, 0);
    check("rst_remote", remote_cred_o, 8'h88);
    check("rst_err", cred_err_o, 0);
    check("rst_vc_ready", vc_ready_o, 0);
    tick();
    rst = 1'b0; vc_valid = 2'b11; link_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vc_ready_o != 2'b00) begin
        g[n] = int'(vc_ready_o[1]);
        n++;
      end
    end
    check("rr_grant_count", n, 16);
    for (int i = 0; i < 16; i++) check("rr_order", g[i], i % 2);
    check("rr_drained_valid", link_valid_o, 0);
    check("rr_drained_remote", remote_cred_o, 8'h00);

    // Five stall cycles with the beat held.
    tick();
    rst = 1'b1; vc_valid = 2'b00; link_ready = 1'b0;
    tick();
    rst = 1'b0; vc_valid = 2'b01;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", link_valid_o, 1);
      check("stall_data_valid", link_data_valid_o, 1);
      check("stall_data_vc", link_data_vc_o, 0);
      check("stall_cred", link_cred_o, 0);
      check("stall_no_ready", vc_ready_o, 0);
      tick();
    end
    link_ready = 1'b1; vc_valid = 2'b00;
    @(negedge clk);
    check("stall_release_ready", vc_ready_o, 2'b01);
`ifdef NOC_BRIDGE_SCHED_STATS_EN
    check("stall_stat", stat_stall_cycles_o, 5);
`else
    check("stall_stat", stat_stall_cycles_o, 0);
`endif
    tick();
    @(negedge clk);
    check("stall_after_valid", link_valid_o, 0);

    // Forced credit-only beat for VC1.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; vc_consumed = 2'b10;
    repeat (4) tick();
    vc_consumed = 2'b00;
    wait_valid("credonly", ok);
    if (ok) begin
      check("credonly_dv", link_data_valid_o, 0);
      check("credonly_vc", link_cred_vc_o, 1);
      check("credonly_amt", link_cred_o, 4);
    end
    tick();
    @(negedge clk);
    check("credonly_after_valid", link_valid_o, 0);
    check("credonly_model_owed1", m_owed[1], 0);

    // Consume during OFFER of a beat carrying 3 credits for VC0.
    tick();
    rst = 1'b1; link_ready = 1'b0;
    tick();
    rst = 1'b0; vc_consumed = 2'b01;
    repeat (3) tick();
    vc_consumed = 2'b00; vc_valid = 2'b01;
    tick();
    @(negedge clk);
    check("pb_valid", link_valid_o, 1);
    check("pb_cred_vc", link_cred_vc_o, 0);
    check("pb_cred", link_cred_o, 3);
    tick();
    vc_consumed = 2'b01;
    tick();
    vc_consumed = 2'b00; link_ready = 1'b1; vc_valid = 2'b00;
    @(negedge clk);
    check("pb_commit_ready", vc_ready_o, 2'b01);
    tick();
    @(negedge clk);
    check("pb_after_valid", link_valid_o, 0);
    check("pb_model_owed0", m_owed[0], 1);
    tick();
    vc_consumed = 2'b01;
    repeat (3) tick();
    vc_consumed = 2'b00;
    wait_valid("pb_rest", ok);
    if (ok) begin
      check("pb_rest_dv", link_data_valid_o, 0);
      check("pb_rest_vc", link_cred_vc_o, 0);
      check("pb_rest_amt", link_cred_o, 4);
    end

    // Zero remote credit, then two credits returned.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; vc_valid = 2'b11;
    repeat (20) tick();
    vc_valid = 2'b01; cred_valid = 1'b1; cred_vc = 1'b0; cred_amount = 4'd2;
    tick();
    cred_valid = 1'b0; cred_amount = 4'd0;
    n = 0; first = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (vc_ready_o[0]) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check("ret_grants", n, 2);
    check("ret_first", first, 1);
    check("ret_stall_valid", link_valid_o, 0);
    check("ret_remote", remote_cred_o, 8'h00);

    // Overflow on VC1 saturates and stays sticky until reset.
    tick();
    rst = 1'b1; vc_valid = 2'b00;
    tick();
    rst = 1'b0; cred_valid = 1'b1; cred_vc = 1'b1; cred_amount = 4'd1;
    tick();
    cred_valid = 1'b0; cred_amount = 4'd0;
    @(negedge clk);
    check("ovf_remote", remote_cred_o, 8'h88);
    check("ovf_err", cred_err_o, 1);
    repeat (3) tick();
    @(negedge clk);
    check("ovf_err_sticky", cred_err_o, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ovf_err_cleared", cred_err_o, 0);

    // Equal owed counts: VC0 first, VC1 back-to-back.
    tick();
    vc_consumed = 2'b11;
    repeat (4) tick();
    vc_consumed = 2'b00;
    wait_valid("tie", ok);
    if (ok) begin
      check("tie_first_dv", link_data_valid_o, 0);
      check("tie_first_vc", link_cred_vc_o, 0);
      check("tie_first_amt", link_cred_o, 4);
      @(negedge clk);
      check("tie_second_valid", link_valid_o, 1);
      check("tie_second_vc", link_cred_vc_o, 1);
      check("tie_second_amt", link_cred_o, 4);
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
